step_pulse_shaper: RTL

- Downstream stage of the motion user_logic: takes single-cycle step requests plus direction from the motion core and drives the physical stepper driver pins S_Step, S_Dir and S_Enable with programmable timing.
- Enforces direction setup, pulse-high width and pulse-low width, and buffers one pending step.
- Gates steps against synchronised endstops and keeps a signed position counter of pulses actually emitted.

---
 rtl/step_pulse_shaper.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/step_pulse_shaper.sv
// step_pulse_shaper
//   Turns single-cycle step requests from the motion core into properly
//   timed stepper-driver pin activity. It enforces a direction setup time
//   before each rising edge, a programmable high width, and a programmable
//   minimum low time. One request can be buffered while a pulse is in
//   flight. Steps toward an active endstop are suppressed, and a signed
//   position counter tracks the pulses that were actually emitted.
//
// Ports
//   Bus2IP_Clk     sole clock
//   Bus2IP_Resetn  synchronous reset, active-low
//   Step_Req       single-cycle step request
//   Step_Dir       direction of Step_Req (1 = positive)
//   Enable_Req     driver enable request
//   Pulse_Width    S_Step high time in clocks (0 behaves as 1)
//   Low_Width      minimum S_Step low time in clocks (0 behaves as 1)
//   Dir_Setup      clocks from an S_Dir change to the S_Step rise (0 behaves as 1)
//   Limit_En       enables endstop gating
//   E_Min, E_Max   asynchronous endstops, active-high
//   Pos_Load       loads Pos_Data into Position (wins over a same-edge step)
//   Pos_Data       load value for Position
//   S_Step, S_Dir, S_Enable   driver pins
//   Busy           FSM active or a step is pending
//   Step_Drop      one-cycle pulse when a request is lost
//   Limit_Hit      one-cycle pulse when an endstop suppresses a step
//   Position       two's-complement count of emitted steps
module step_pulse_shaper #(
  parameter int CNT_W = 16,
  parameter int POS_W = 32
) (
  input  logic             Bus2IP_Clk,
  input  logic             Bus2IP_Resetn,
  input  logic             Step_Req,
  input  logic             Step_Dir,
  input  logic             Enable_Req,
  input  logic [CNT_W-1:0] Pulse_Width,
  input  logic [CNT_W-1:0] Low_Width,
  input  logic [CNT_W-1:0] Dir_Setup,
  input  logic             Limit_En,
  input  logic             E_Min,
  input  logic             E_Max,
  input  logic             Pos_Load,
  input  logic [POS_W-1:0] Pos_Data,
  output logic             S_Step,
  output logic             S_Dir,
  output logic             S_Enable,
  output logic             Busy,
  output logic             Step_Drop,
  output logic             Limit_Hit,
  output logic [POS_W-1:0] Position
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_dir_q, pend_dir_d;
  logic             s_step_q, s_step_d;
  logic             s_dir_q, s_dir_d;
  logic             s_enable_q;
  logic             step_drop_q, step_drop_d;
  logic             limit_hit_q, limit_hit_d;
  logic [POS_W-1:0] position_q, position_d;
  logic             e_min_meta_q, e_min_s_q;
  logic             e_max_meta_q, e_max_s_q;

  logic [CNT_W-1:0] pw_eff, lw_eff, ds_eff;
  logic             launch_go, launch_dir;
  logic             inc_en, inc_dir;

  // Zero-length phases behave as one clock.
  assign pw_eff = (Pulse_Width == '0) ? CNT_W'(1) : Pulse_Width;
  assign lw_eff = (Low_Width   == '0) ? CNT_W'(1) : Low_Width;
  assign ds_eff = (Dir_Setup   == '0) ? CNT_W'(1) : Dir_Setup;

  // Next-state logic. The FSM phase handling runs first and may request a
  // launch of the pending entry; new-request acceptance is then decided from
  // the registered state and pending flag, so both can happen on one edge
  // without ever consuming and storing the pending slot simultaneously.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    s_step_d     = s_step_q;
    s_dir_d      = s_dir_q;
    step_drop_d  = 1'b0;
    limit_hit_d  = 1'b0;
    position_d   = position_q;
    launch_go    = 1'b0;
    launch_dir   = 1'b0;
    inc_en       = 1'b0;
    inc_dir      = 1'b0;

    case (state_q)
      IDLE: begin
        // A request stored while LOW was finishing launches here.
        if (pend_valid_q && Enable_Req) begin
          launch_go    = 1'b1;
          launch_dir   = pend_dir_q;
          pend_valid_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d  = HIGH;
          s_step_d = 1'b1;
          cnt_d    = pw_eff;
          inc_en   = 1'b1;
          inc_dir  = s_dir_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d  = LOW;
          s_step_d = 1'b0;
          cnt_d    = lw_eff;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          if (pend_valid_q && Enable_Req) begin
            launch_go    = 1'b1;
            launch_dir   = pend_dir_q;
            pend_valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Losing the enable silently discards whatever is buffered.
    if (!Enable_Req) begin
      pend_valid_d = 1'b0;
    end

    if (Step_Req) begin
      if (!s_enable_q || !Enable_Req) begin
        step_drop_d = 1'b1;
      end else if (state_q == IDLE && !pend_valid_q) begin
        launch_go  = 1'b1;
        launch_dir = Step_Dir;
      end else if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_dir_d   = Step_Dir;
      end else begin
        step_drop_d = 1'b1;
      end
    end

    // A suppressed launch leaves state_d at IDLE, which both the IDLE and
    // LOW-completion paths have already arranged.
    if (launch_go) begin
      if (Limit_En && (launch_dir ? e_max_s_q : e_min_s_q)) begin
        limit_hit_d = 1'b1;
      end else if (launch_dir != s_dir_q) begin
        s_dir_d = launch_dir;
        state_d = SETUP;
        cnt_d   = ds_eff;
      end else begin
        state_d  = HIGH;
        s_step_d = 1'b1;
        cnt_d    = pw_eff;
        inc_en   = 1'b1;
        inc_dir  = launch_dir;
      end
    end

    if (Pos_Load) begin
      position_d = Pos_Data;
    end else if (inc_en) begin
      position_d = inc_dir ? position_q + POS_W'(1) : position_q - POS_W'(1);
    end
  end

  // All state, including the endstop synchronisers, with synchronous reset.
  always_ff @(posedge Bus2IP_Clk) begin
    if (!Bus2IP_Resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= 1'b0;
      s_step_q     <= 1'b0;
      s_dir_q      <= 1'b0;
      s_enable_q   <= 1'b0;
      step_drop_q  <= 1'b0;
      limit_hit_q  <= 1'b0;
      position_q   <= '0;
      e_min_meta_q <= 1'b0;
      e_min_s_q    <= 1'b0;
      e_max_meta_q <= 1'b0;
      e_max_s_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
      s_step_q     <= s_step_d;
      s_dir_q      <= s_dir_d;
      s_enable_q   <= Enable_Req;
      step_drop_q  <= step_drop_d;
      limit_hit_q  <= limit_hit_d;
      position_q   <= position_d;
      e_min_meta_q <= E_Min;
      e_min_s_q    <= e_min_meta_q;
      e_max_meta_q <= E_Max;
      e_max_s_q    <= e_max_meta_q;
    end
  end

  assign S_Step    = s_step_q;
  assign S_Dir     = s_dir_q;
  assign S_Enable  = s_enable_q;
  assign Busy      = (state_q != IDLE) || pend_valid_q;
  assign Step_Drop = step_drop_q;
  assign Limit_Hit = limit_hit_q;
  assign Position  = position_q;

endmodule
